// File: rtl/axi_bist_pkg.sv
// Shared types and AXI constants for the memory BIST controller.
// Imported by the BIST top level.
package axi_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW,
        WR_DATA,
        WR_RESP,
        RD_AR,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

endpackage

// File: rtl/axi_bist_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and
// flags expiry on the cycle the count would reach the limit.
module axi_bist_watchdog #(
    parameter int limit = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(limit + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && !clear && (cnt == CW'(limit - 1));

endmodule

// File: rtl/axi_mem_bist.sv
// AXI4 master BIST: writes seed-derived INCR bursts, reads them back
// and counts mismatches, with a handshake watchdog.
module axi_mem_bist
    import axi_bist_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int id_width = 4,
    parameter int burst_len = 16,
    parameter logic [id_width-1:0] bist_id = 'h3,
    parameter int timeout = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [addr_width-1:0]   base_addr,
    input  logic [7:0]              num_bursts,
    input  logic [data_width-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic                    timed_out,
    output logic [id_width-1:0]     awid,
    output logic [addr_width-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [data_width-1:0]   wdata,
    output logic [data_width/8-1:0] wstrb,
    output logic                    wvalid,
    output logic                    wlast,
    input  logic                    wready,
    input  logic [id_width-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [id_width-1:0]     arid,
    output logic [addr_width-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [data_width-1:0]   rdata,
    input  logic [id_width-1:0]     rid,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    input  logic                    rlast,
    output logic                    rready
);

    localparam int BW = $clog2(burst_len + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(burst_len - 1);
    localparam logic [addr_width-1:0] BURST_BYTES = addr_width'(burst_len * 4);

    state_t state, state_nxt;

    logic [addr_width-1:0] base_q;
    logic [addr_width-1:0] burst_addr;
    logic [7:0]            nb_q;
    logic [7:0]            b_q;
    logic [data_width-1:0] seed_q;
    logic [data_width-1:0] k_q;
    logic [data_width-1:0] pattern;
    logic [BW-1:0]         beat_q;
    logic [15:0]           err_q;

    logic idle_like, start_ok;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic beat_last, burst_last;
    logic b_bad, r_bad, err_inc;
    logic wd_expired;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign start_ok  = start && idle_like;

    // Handshakes decoded from state so the watchdog path never loops
    // back through the FSM output logic.
    assign aw_hs  = (state == WR_AW) && awready;
    assign w_hs   = (state == WR_DATA) && wready;
    assign b_hs   = (state == WR_RESP) && bvalid;
    assign ar_hs  = (state == RD_AR) && arready;
    assign r_hs   = (state == RD_DATA) && rvalid;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

    assign beat_last  = (beat_q == LAST_BEAT);
    assign burst_last = ((b_q + 8'd1) == nb_q);
    assign pattern    = seed_q + k_q;
    assign burst_addr = base_q + addr_width'(b_q) * BURST_BYTES;

    assign b_bad = (bresp != RESP_OKAY) || (bid != bist_id);
    assign r_bad = (rdata != pattern) || (rresp != RESP_OKAY) ||
                   (rid != bist_id) || (rlast != beat_last);
    assign err_inc = (b_hs && b_bad) || (r_hs && r_bad);

    axi_bist_watchdog #(
        .limit (timeout)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (idle_like || any_hs),
        .enable  (!idle_like),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_bursts == 8'd0) ? DONE : WR_AW;
                end
            end
            WR_AW: begin
                awvalid = 1'b1;
                if (awready) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                wvalid = 1'b1;
                wlast  = beat_last;
                if (wready && beat_last) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = burst_last ? RD_AR : WR_AW;
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid && beat_last) begin
                    state_nxt = burst_last ? DONE : RD_AR;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (wd_expired) state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q    <= '0;
            nb_q      <= '0;
            seed_q    <= '0;
            b_q       <= '0;
            k_q       <= '0;
            beat_q    <= '0;
            err_q     <= '0;
            timed_out <= 1'b0;
        end else if (start_ok) begin
            base_q    <= base_addr;
            nb_q      <= num_bursts;
            seed_q    <= seed;
            b_q       <= '0;
            k_q       <= '0;
            beat_q    <= '0;
            err_q     <= '0;
            timed_out <= 1'b0;
        end else begin
            if (wd_expired) timed_out <= 1'b1;
            if (w_hs || r_hs) begin
                k_q    <= k_q + 1'b1;
                beat_q <= beat_last ? '0 : beat_q + 1'b1;
            end
            // Pattern index restarts when the write phase hands over to reads.
            if (b_hs) begin
                b_q <= burst_last ? 8'd0 : b_q + 8'd1;
                if (burst_last) k_q <= '0;
            end
            if (r_hs && beat_last) b_q <= b_q + 8'd1;
            if (err_inc && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
        end
    end

    assign busy      = !idle_like;
    assign done      = (state == DONE);
    assign pass      = done && (err_q == 16'd0) && !timed_out;
    assign err_count = err_q;

    assign awid    = bist_id;
    assign arid    = bist_id;
    assign awaddr  = burst_addr;
    assign araddr  = burst_addr;
    assign awlen   = 8'(burst_len - 1);
    assign arlen   = 8'(burst_len - 1);
    assign awsize  = SIZE_4B;
    assign arsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign arburst = BURST_INCR;
    assign wdata   = pattern;
    assign wstrb   = '1;

endmodule

// File: tb/tb_axi_mem_bist.sv
// Bench for axi_mem_bist: behavioural AXI slave RAM plus address and
// write-data scoreboards, one task per scenario.
module tb_axi_mem_bist;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  num_bursts = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass, timed_out;
    logic [15:0] err_count;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wlast, wready;
    logic        bvalid, bready, arvalid, arready, rvalid, rlast, rready;

    always #5 clk = ~clk;

    axi_mem_bist dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .seed(seed), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .timed_out(timed_out),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rid(rid), .rresp(rresp),
        .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem [1024];
    logic [31:0] exp_w[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];

    bit          aw_busy, b_pend, r_act;
    logic [31:0] w_addr, r_addr;
    int          w_cnt, r_beat, r_len, aw_hold;

    bit          ev_aw, ev_w, ev_b, ev_ar, ev_r;
    logic [31:0] ev_awaddr, ev_wdata, ev_araddr;
    logic        ev_wlast;

    task automatic slave_reset();
        aw_busy = 0; b_pend = 0; r_act = 0;
        w_addr = '0; r_addr = '0; w_cnt = 0; r_beat = 0; r_len = 0;
        aw_hold = 0;
        awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
        arready = 0; rvalid = 0; rdata = '0; rid = '0; rresp = '0;
        rlast = 0;
    endtask

    // Called once per negedge: drives slave inputs for the coming posedge
    // and records which handshakes that edge will complete.
    task automatic slave_step();
        awready = !aw_busy && (aw_hold == 0);
        wready  = aw_busy && !b_pend;
        bvalid  = b_pend;
        bid     = awid;
        bresp   = 2'b00;
        arready = !r_act;
        rvalid  = r_act;
        rdata   = r_act ? mem[10'((r_addr >> 2) + r_beat)] : '0;
        rlast   = r_act && (r_beat == r_len - 1);
        rid     = arid;
        rresp   = 2'b00;
        if (aw_hold > 0) aw_hold--;
        ev_aw = 0; ev_w = 0; ev_b = 0; ev_ar = 0; ev_r = 0;
        if (awvalid && awready) begin
            ev_aw = 1; ev_awaddr = awaddr;
            aw_busy = 1; w_addr = awaddr; w_cnt = 0;
        end
        if (wvalid && wready) begin
            ev_w = 1; ev_wdata = wdata; ev_wlast = wlast;
            mem[10'((w_addr >> 2) + w_cnt)] = wdata;
            w_cnt++;
            if (wlast) b_pend = 1;
        end
        if (bvalid && bready) begin
            ev_b = 1; b_pend = 0; aw_busy = 0;
        end
        if (arvalid && arready) begin
            ev_ar = 1; ev_araddr = araddr;
            r_act = 1; r_addr = araddr; r_beat = 0; r_len = int'(arlen) + 1;
        end
        if (rvalid && rready) begin
            ev_r = 1; r_beat++;
            if (rlast) r_act = 0;
        end
    endtask

    task automatic run_bist(input logic [31:0] base, input logic [7:0] nb,
                            input logic [31:0] sd, input int corrupt,
                            input int restart_at, output bit finished);
        int wb;
        int nb_b;
        logic [31:0] e;
        exp_w.delete(); exp_aw.delete(); exp_ar.delete();
        for (int b = 0; b < int'(nb); b++) begin
            exp_aw.push_back(base + 32'(b * 64));
            exp_ar.push_back(base + 32'(b * 64));
        end
        for (int k = 0; k < int'(nb) * 16; k++) exp_w.push_back(sd + 32'(k));
        @(negedge clk);
        base_addr = base; num_bursts = nb; seed = sd; start = 1;
        slave_step();
        finished = 0; wb = 0; nb_b = 0;
        for (int cyc = 1; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                base_addr = 32'h0000_0400;
                seed = 32'hDEAD_0000;
            end
            slave_step();
            if (ev_aw) begin
                n_checks++;
                if (exp_aw.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_unexpected: got addr %h, required none", ev_awaddr);
                end else begin
                    e = exp_aw.pop_front();
                    if (ev_awaddr !== e) begin
                        n_fail++;
                        $display("FAIL awaddr: got %h required %h", ev_awaddr, e);
                    end
                end
            end
            if (ev_w) begin
                n_checks++;
                if (exp_w.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_unexpected: got data %h, required none", ev_wdata);
                end else begin
                    e = exp_w.pop_front();
                    if ({ev_wlast, ev_wdata} !== {(wb % 16) == 15, e}) begin
                        n_fail++;
                        $display("FAIL wbeat %0d: got last=%b data=%h required last=%b data=%h",
                                 wb, ev_wlast, ev_wdata, (wb % 16) == 15, e);
                    end
                end
                wb++;
            end
            if (ev_b) begin
                nb_b++;
                if (nb_b == int'(nb) && corrupt >= 0) mem[corrupt] = 32'h0;
            end
            if (ev_ar) begin
                n_checks++;
                if (exp_ar.size() == 0) begin
                    n_fail++;
                    $display("FAIL ar_unexpected: got addr %h, required none", ev_araddr);
                end else begin
                    e = exp_ar.pop_front();
                    if (ev_araddr !== e) begin
                        n_fail++;
                        $display("FAIL araddr: got %h required %h", ev_araddr, e);
                    end
                end
            end
            if (done) finished = 1;
        end
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL run_done: got done=%b after budget, required 1", done);
        end
        n_checks++;
        if (exp_w.size() + exp_aw.size() + exp_ar.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d left, required 0/0/0",
                     exp_aw.size(), exp_w.size(), exp_ar.size());
        end
    endtask

    task automatic test_reset();
        rst = 0; start = 0;
        slave_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b required 00000",
                     {awvalid, wvalid, bready, arvalid, rready});
        end
        n_checks++;
        if ({busy, done, timed_out, pass} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %b required 0000",
                     {busy, done, timed_out, pass});
        end
        n_checks++;
        if (err_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_err: got %h required 0000", err_count);
        end
        n_checks++;
        if ({awid, arid} !== 8'h33) begin
            n_fail++;
            $display("FAIL ids: got %h required 33", {awid, arid});
        end
        n_checks++;
        if ({awsize, arsize, awburst, arburst, awlen, arlen, wstrb} !==
            {3'b010, 3'b010, 2'b01, 2'b01, 8'h0F, 8'h0F, 4'hF}) begin
            n_fail++;
            $display("FAIL consts: got %b required %b",
                     {awsize, arsize, awburst, arburst, awlen, arlen, wstrb},
                     {3'b010, 3'b010, 2'b01, 2'b01, 8'h0F, 8'h0F, 4'hF});
        end
        rst = 1;
    endtask

    task automatic test_zero_bursts();
        bit any_valid;
        @(negedge clk);
        base_addr = 32'h0; num_bursts = 8'd0; seed = 32'h5; start = 1;
        any_valid = awvalid | wvalid | arvalid;
        slave_step();
        @(negedge clk);
        start = 0;
        slave_step();
        n_checks++;
        if ({done, pass, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL zero_done: got done/pass/busy=%b required 110",
                     {done, pass, busy});
        end
        for (int i = 0; i < 6; i++) begin
            any_valid |= awvalid | wvalid | arvalid;
            @(negedge clk);
            slave_step();
        end
        n_checks++;
        if (any_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_valid: got a valid raised, required none");
        end
    endtask

    task automatic test_write_read();
        bit fin;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        slave_reset();
        run_bist(32'h0, 8'd4, 32'h1000_0000, -1, -1, fin);
        n_checks++;
        if ({done, pass, err_count} !== {2'b11, 16'h0}) begin
            n_fail++;
            $display("FAIL wr_rd_status: got done=%b pass=%b err=%h required 1 1 0000",
                     done, pass, err_count);
        end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (mem[i] !== 32'h1000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL mem[%0d]: got %h required %h",
                         i, mem[i], 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_corrupt();
        bit fin;
        slave_reset();
        run_bist(32'h0, 8'd4, 32'h1000_0000, 5, -1, fin);
        n_checks++;
        if ({done, pass, timed_out, err_count} !== {3'b100, 16'd1}) begin
            n_fail++;
            $display("FAIL corrupt: got done=%b pass=%b to=%b err=%0d required 1 0 0 1",
                     done, pass, timed_out, err_count);
        end
    endtask

    task automatic test_timeout();
        int c0;
        int c1;
        bit fin;
        slave_reset();
        aw_hold = 2000;
        @(negedge clk);
        base_addr = 32'h0; num_bursts = 8'd1; seed = 32'h77; start = 1;
        slave_step();
        c0 = -1; c1 = -1; fin = 0;
        for (int cyc = 1; cyc < 1500 && !fin; cyc++) begin
            @(negedge clk);
            start = 0;
            slave_step();
            if (c0 < 0 && awvalid) c0 = cyc;
            if (c1 < 0 && timed_out) c1 = cyc;
            if (done) fin = 1;
        end
        n_checks++;
        if (c1 - c0 !== 1024 || c0 < 0) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles (aw at %0d) required 1024",
                     c1 - c0, c0);
        end
        n_checks++;
        if ({fin, done, pass, timed_out, awvalid, wvalid, arvalid} !== 7'b1101000) begin
            n_fail++;
            $display("FAIL timeout_state: got fin/done/pass/to/aw/w/ar=%b required 1101000",
                     {fin, done, pass, timed_out, awvalid, wvalid, arvalid});
        end
        aw_hold = 0;
    endtask

    task automatic test_reset_mid_burst();
        int wcount;
        bit hit;
        bit fin;
        slave_reset();
        @(negedge clk);
        base_addr = 32'h0; num_bursts = 8'd4; seed = 32'h2000_0000; start = 1;
        slave_step();
        wcount = 0; hit = 0;
        for (int cyc = 1; cyc < 200 && !hit; cyc++) begin
            @(negedge clk);
            start = 0;
            if (wcount == 6) begin
                rst = 0;
                hit = 1;
            end else begin
                slave_step();
                if (ev_w) wcount++;
            end
        end
        @(negedge clk);
        rst = 1;
        n_checks++;
        if ({hit, awvalid, wvalid, bready, arvalid, rready, busy, done} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL mid_reset: got hit/aw/w/b/ar/r/busy/done=%b required 10000000",
                     {hit, awvalid, wvalid, bready, arvalid, rready, busy, done});
        end
        slave_reset();
        run_bist(32'h0, 8'd4, 32'h3000_0000, -1, -1, fin);
        n_checks++;
        if ({done, pass, err_count} !== {2'b11, 16'h0}) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: got done=%b pass=%b err=%h required 1 1 0000",
                     done, pass, err_count);
        end
    endtask

    task automatic test_back_to_back();
        bit fin;
        slave_reset();
        run_bist(32'h0000_0080, 8'd4, 32'hA5A5_0000, -1, 10, fin);
        n_checks++;
        if ({done, pass, err_count} !== {2'b11, 16'h0}) begin
            n_fail++;
            $display("FAIL b2b_status: got done=%b pass=%b err=%h required 1 1 0000",
                     done, pass, err_count);
        end
        for (int i = 0; i < 64; i += 9) begin
            n_checks++;
            if (mem[32 + i] !== 32'hA5A5_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_mem[%0d]: got %h required %h",
                         32 + i, mem[32 + i], 32'hA5A5_0000 + 32'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_bursts();
        test_write_read();
        test_corrupt();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_bist.md
Name: axi_mem_bist

Overview:
- Built-in self-test controller that acts as AXI4 master to axi_slave's internal RAM.
- On start, writes num_bursts INCR bursts of a seed-derived pattern from base_addr upward, then reads them back and compares every beat.
- Reports pass/fail, an error count and a watchdog timeout.
- Sits between the test/config logic and the slave's AXI port; the only master on that port while busy.

Parameters:
- addr_width, 32, AXI address width
- data_width, 32, AXI data width; fixed at 32 (slave RAM word)
- id_width, 4, AXI ID width
- burst_len, 16, beats per burst (1..256); awlen/arlen = burst_len-1
- bist_id, 4'h3, constant ID driven on awid/arid
- timeout, 1024, watchdog limit in cycles without a handshake

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; ignored unless state IDLE or DONE
- base_addr  in  addr_width  start byte address, word aligned; sampled at start
- num_bursts  in  8  burst count; sampled at start
- seed  in  data_width  pattern seed; sampled at start
- busy  out  1  high from cycle after accepted start until DONE
- done  out  1  level; high in DONE until next start or reset
- pass  out  1  done && err_count==0 && !timed_out
- err_count  out  16  saturating mismatch/response error count
- timed_out  out  1  watchdog fired
- AXI master (widths as axi_slave):
  - awid/awaddr/awlen/awsize/awburst/awvalid out, awready in
  - wdata/wstrb/wvalid/wlast out, wready in
  - bid/bresp/bvalid in, bready out
  - arid/araddr/arlen/arsize/arburst/arvalid out, arready in
  - rdata/rid/rresp/rvalid/rlast in, rready out

Behaviour:
- Reset (rst low at clk edge), next cycle:
  - all valids, bready, rready, busy, done, timed_out = 0; err_count = 0; state IDLE.
  - Applies mid-operation too: the in-flight burst is abandoned with no drain.
- Constant outputs:
  - awid = arid = bist_id at all times. The slave echoes arid combinationally into rid, so arid must never change.
  - awsize = arsize = 3'b010; awburst = arburst = 2'b01 (INCR); wstrb all ones.
- States: IDLE -> WR_AW -> WR_DATA -> WR_RESP -> (WR_AW | RD_AR) ; RD_AR -> RD_DATA -> (RD_AR | DONE) ; any -> DONE on timeout. DONE -> WR_AW on start.
- start accepted in IDLE/DONE:
  - Latch inputs; clear err_count, timed_out, burst index b and global beat index k.
  - num_bursts==0: go straight to DONE on the next cycle, pass = 1.
- Burst address: base_addr + b*burst_len*4, modulo 2^addr_width.
- Pattern for global beat k: seed + k, modulo 2^data_width. k restarts at 0 for the read phase.
- Handshake rules:
  - A valid, once raised, holds with payload stable until valid && ready is sampled.
  - One outstanding transaction only: next AW waits for B; next AR waits for the R beat with rlast.
- WR_AW: awvalid=1; on handshake go to WR_DATA.
- WR_DATA: wvalid=1, wdata=pattern(k), wlast on beat burst_len-1; k++ on each handshake; after the last beat go to WR_RESP.
- WR_RESP:
  - bready=1. On bvalid: err++ if bresp!=0 or bid!=bist_id.
  - b++. If b==num_bursts, set b=0 and go to RD_AR; else go to WR_AW.
- RD_AR: arvalid=1; on handshake go to RD_DATA.
- RD_DATA:
  - rready=1 held. Each rvalid beat is one error check (err++ at most once per beat): rdata!=pattern(k), rresp!=0, rid!=bist_id, or rlast != (beat==burst_len-1). k++.
  - On the final beat, b++; go to DONE when b==num_bursts, else to RD_AR.
- err_count saturates at 16'hFFFF.
- Watchdog:
  - Counter cleared on any handshake and in IDLE/DONE; increments otherwise.
  - On reaching timeout: timed_out=1, drop all valids/readies, go to DONE.
- Simultaneous start and timeout cannot occur, since start is ignored while busy.

Decomposition:
- Package axi_bist_pkg: state encoding, AXI constants RESP_OKAY=2'b00, BURST_INCR=2'b01, SIZE_4B=3'b010.
- Sub-module axi_bist_watchdog: counter with clear/enable inputs and an expired output.

Test Plan:
- base_addr=0, num_bursts=4, seed=32'h1000_0000, against axi_slave -> 4 AW/B, 4 AR bursts of 16; mem[0..63]=1000_0000..1000_003F; done=1, pass=1, err_count=0.
- num_bursts=0, start -> done=1 one cycle later, pass=1, no AXI valids ever raised.
- Same as test 1, but backdoor-write mem[5]=0 after the last B, before the first AR -> err_count=1, pass=0.
- Slave model holds awready low for 2000 cycles, timeout=1024 -> timed_out=1 exactly 1024 cycles after awvalid rose, done=1, pass=0, awvalid dropped.
- rst low for one cycle during the 7th W beat -> next cycle all valids 0, state IDLE, busy=0; a new start then completes with pass=1.
- Second start pulse while busy -> ignored; a single run completes with the original base_addr/seed.
